// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM-like arbiter and its helpers: FSM state,
// access owner and data-size codes.
package sram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  // Code 3 is not listed; consumers treat it as a word access.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

endpackage

// File: rtl/sram_wstrb_gen.sv
// Byte-lane write-enable generator: (size, addr[1:0], wr) -> wen[3:0].
// Purely combinational so it can be shared with other bus front-ends.
module sram_wstrb_gen
  import sram_arb_pkg::*;
(
  input  logic       i_wr,
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_wen
);

  always_comb begin
    o_wen = '0;
    if (i_wr) begin
      case (i_size)
        SZ_BYTE: o_wen = 4'b0001 << i_addr_lo;
        SZ_HALF: o_wen = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        default: o_wen = 4'b1111;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-port SRAM,
// one access at a time, data first with a bounded fetch starvation window.
module sram_like_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [1:0] LAT_LAST   = 2'(RAM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     r_state;
  state_t     w_next_state;
  owner_t     r_owner;
  logic [1:0] r_lat_cnt;
  logic [3:0] r_starve_cnt;

  logic       w_idle;
  logic       w_grant_data;
  logic       w_grant_inst;
  logic       w_grant_any;
  logic       w_done;
  logic [3:0] w_data_wen;
  logic       w_unused_addr_lo;

  // Grants are suppressed while reset is held so every output reads 0 then.
  assign w_idle       = (r_state == IDLE) && resetn;
  assign w_grant_data = w_idle && data_req &&
                        !(inst_req && (r_starve_cnt == STARVE_LIM));
  assign w_grant_inst = w_idle && inst_req && !w_grant_data;
  assign w_grant_any  = w_grant_data || w_grant_inst;
  assign w_done       = (r_state == WAIT) && (r_lat_cnt == LAT_LAST);

  assign w_unused_addr_lo = &{1'b0, inst_addr[1:0]};

  sram_wstrb_gen u_wstrb (
    .i_wr      (data_wr),
    .i_size    (data_size),
    .i_addr_lo (data_addr[1:0]),
    .o_wen     (w_data_wen)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_owner      <= OWN_INST;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_any) begin
        r_owner   <= w_grant_data ? OWN_DATA : OWN_INST;
        r_lat_cnt <= '0;
        if (w_grant_inst || !inst_req)
          r_starve_cnt <= '0;
        else if (r_starve_cnt != STARVE_LIM)
          r_starve_cnt <= r_starve_cnt + 4'd1;
      end else if (r_state == WAIT) begin
        r_lat_cnt <= r_lat_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    inst_addr_ok = w_grant_inst;
    data_addr_ok = w_grant_data;
    ram_en       = w_grant_any;
    ram_wen      = '0;
    ram_addr     = '0;
    ram_wdata    = '0;
    inst_data_ok = w_done && (r_owner == OWN_INST);
    data_data_ok = w_done && (r_owner == OWN_DATA);
    inst_rdata   = '0;
    data_rdata   = '0;

    case (r_state)
      IDLE:    if (w_grant_any) w_next_state = WAIT;
      WAIT:    if (w_done) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase

    if (w_grant_data) begin
      ram_wen   = w_data_wen;
      ram_addr  = {data_addr[31:2], 2'b00};
      ram_wdata = data_wdata;
    end else if (w_grant_inst) begin
      ram_addr  = {inst_addr[31:2], 2'b00};
    end

    if (inst_data_ok) inst_rdata = ram_rdata;
    if (data_data_ok) data_rdata = ram_rdata;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench: one arbiter with RAM_LAT=1 and one with
// RAM_LAT=3 share the requester/RAM inputs; each phase checks one of them.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] ram_rdata = '0;

  logic        d1_inst_aok, d1_inst_dok, d1_data_aok, d1_data_dok, d1_ram_en;
  logic [31:0] d1_inst_rdata, d1_data_rdata, d1_ram_addr, d1_ram_wdata;
  logic [3:0]  d1_ram_wen;
  logic        d3_inst_aok, d3_inst_dok, d3_data_aok, d3_data_dok, d3_ram_en;
  logic [31:0] d3_inst_rdata, d3_data_rdata, d3_ram_addr, d3_ram_wdata;
  logic [3:0]  d3_ram_wen;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.RAM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(d1_inst_aok), .inst_data_ok(d1_inst_dok), .inst_rdata(d1_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(d1_data_aok), .data_data_ok(d1_data_dok), .data_rdata(d1_data_rdata),
    .ram_en(d1_ram_en), .ram_wen(d1_ram_wen), .ram_addr(d1_ram_addr),
    .ram_wdata(d1_ram_wdata), .ram_rdata(ram_rdata)
  );

  sram_like_arbiter #(.RAM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(d3_inst_aok), .inst_data_ok(d3_inst_dok), .inst_rdata(d3_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(d3_data_aok), .data_data_ok(d3_data_dok), .data_rdata(d3_data_rdata),
    .ram_en(d3_ram_en), .ram_wen(d3_ram_wen), .ram_addr(d3_ram_addr),
    .ram_wdata(d3_ram_wdata), .ram_rdata(ram_rdata)
  );

  typedef struct {
    logic        iq, dq, wr;
    logic [1:0]  sz;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wen;
    logic [31:0] raddr, ewd;
    logic        einst;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs;
    inst_req = 1'b0;
    data_req = 1'b0;
    data_wr  = 1'b0;
  endtask

  task automatic do_reset;
    drop_reqs();
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_d1_ctrl", {d1_inst_aok, d1_inst_dok, d1_data_aok, d1_data_dok, d1_ram_en, d1_ram_wen}, '0);
    chk("rst_d1_bus",  d1_ram_addr | d1_ram_wdata | d1_inst_rdata | d1_data_rdata, '0);
    chk("rst_d3_ctrl", {d3_inst_aok, d3_inst_dok, d3_data_aok, d3_data_dok, d3_ram_en, d3_ram_wen}, '0);
    chk("rst_d3_bus",  d3_ram_addr | d3_ram_wdata | d3_inst_rdata | d3_data_rdata, '0);
    step();
    resetn = 1'b1;
    step();
  endtask

  // Holds the requests high and checks owner order and grant spacing on dut1.
  task automatic hold_run(input logic iq, input logic dq, input int n);
    int  last = -1;
    int  k = 0;
    int  cyc = 0;
    logic exp_data;
    inst_req  = iq;
    data_req  = dq;
    data_wr   = 1'b0;
    data_size = 2'd2;
    while (k < n && cyc < n * 4) begin
      @(negedge clk);
      if (d1_inst_aok || d1_data_aok) begin
        exp_data = dq && !(iq && ((k % 5) == 4));
        chk($sformatf("hold%0d%0d_owner%0d", iq, dq, k), {31'b0, d1_data_aok}, {31'b0, exp_data});
        if (last >= 0) chk($sformatf("hold%0d%0d_gap%0d", iq, dq, k), cyc - last, 2);
        last = cyc;
        k++;
      end
      cyc++;
    end
    chk($sformatf("hold%0d%0d_count", iq, dq), k, n);
    step();
    drop_reqs();
    step();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd2, 32'hBFC00004, 32'hDEADBEEF, 32'h24010001, 4'h0, 32'hBFC00004, 32'h00000000, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 2'd0, 32'h80001003, 32'h5A5A5A5A, 32'h11110000, 4'h8, 32'h80001000, 32'h5A5A5A5A, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 2'd1, 32'h80001002, 32'h12341234, 32'h22220000, 4'hC, 32'h80001000, 32'h12341234, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h80001001, 32'hCAFEF00D, 32'h33330000, 4'hF, 32'h80001000, 32'hCAFEF00D, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 2'd0, 32'h80002000, 32'h11111111, 32'h44440000, 4'h1, 32'h80002000, 32'h11111111, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 2'd1, 32'h80002001, 32'h22222222, 32'h55550000, 4'h3, 32'h80002000, 32'h22222222, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 2'd3, 32'h80002006, 32'h33333333, 32'h66660000, 4'hF, 32'h80002004, 32'h33333333, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h80003008, 32'h44444444, 32'h87654321, 4'h0, 32'h80003008, 32'h44444444, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h80004005, 32'h99999999, 32'h0F0F0F0F, 4'h0, 32'h80004004, 32'h99999999, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 2'd0, 32'h80004001, 32'h77777777, 32'h77770000, 4'h2, 32'h80004000, 32'h77777777, 1'b0};

    resetn    = 1'b1;
    ram_rdata = 32'h24010001;
    #1 resetn = 1'b0;
    step();
    do_reset();

    // Single-access vectors on the RAM_LAT=1 arbiter.
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      inst_req   = v.iq;
      data_req   = v.dq;
      data_wr    = v.wr;
      data_size  = v.sz;
      inst_addr  = v.addr;
      data_addr  = v.addr;
      data_wdata = v.wdata;
      ram_rdata  = v.rdata;
      @(negedge clk);
      chk($sformatf("vec%0d_inst_aok", i), {31'b0, d1_inst_aok}, {31'b0, v.einst});
      chk($sformatf("vec%0d_data_aok", i), {31'b0, d1_data_aok}, {31'b0, ~v.einst});
      chk($sformatf("vec%0d_ram_en", i), {31'b0, d1_ram_en}, 32'd1);
      chk($sformatf("vec%0d_wen", i), {28'b0, d1_ram_wen}, {28'b0, v.wen});
      chk($sformatf("vec%0d_raddr", i), d1_ram_addr, v.raddr);
      chk($sformatf("vec%0d_wdata", i), d1_ram_wdata, v.ewd);
      chk($sformatf("vec%0d_dok_early", i), {30'b0, d1_inst_dok, d1_data_dok}, '0);
      step();
      drop_reqs();
      @(negedge clk);
      chk($sformatf("vec%0d_inst_dok", i), {31'b0, d1_inst_dok}, {31'b0, v.einst});
      chk($sformatf("vec%0d_data_dok", i), {31'b0, d1_data_dok}, {31'b0, ~v.einst});
      chk($sformatf("vec%0d_rdata", i), v.einst ? d1_inst_rdata : d1_data_rdata, v.rdata);
      chk($sformatf("vec%0d_wait_en", i), {31'b0, d1_ram_en}, '0);
      step();
    end

    // Fetch alone, then sustained contention on the RAM_LAT=1 arbiter.
    inst_addr = 32'hBFC00004;
    data_addr = 32'h80000010;
    hold_run(1'b1, 1'b0, 3);
    hold_run(1'b1, 1'b1, 10);

    // RAM_LAT=3: data read held high, re-granted right after data_ok.
    do_reset();
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_size = 2'd2;
    data_addr = 32'h80006000;
    ram_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("lat3_grant", {31'b0, d3_data_aok}, 32'd1);
    for (int c = 1; c <= 3; c++) begin
      step();
      @(negedge clk);
      chk($sformatf("lat3_aok_T%0d", c), {31'b0, d3_data_aok}, '0);
      chk($sformatf("lat3_dok_T%0d", c), {31'b0, d3_data_dok}, {31'b0, (c == 3)});
      if (c == 3) chk("lat3_rdata", d3_data_rdata, 32'hA5A5A5A5);
    end
    step();
    @(negedge clk);
    chk("lat3_regrant", {31'b0, d3_data_aok}, 32'd1);
    step();
    drop_reqs();
    repeat (4) step();

    // Reset pulled during the data_ok cycle of a RAM_LAT=1 read.
    do_reset();
    data_req  = 1'b1;
    data_addr = 32'h80005000;
    @(negedge clk);
    chk("rmid_grant", {31'b0, d1_data_aok}, 32'd1);
    step();
    resetn = 1'b0;
    @(negedge clk);
    chk("rmid_ctrl", {d1_inst_aok, d1_inst_dok, d1_data_aok, d1_data_dok, d1_ram_en, d1_ram_wen}, '0);
    chk("rmid_bus", d1_ram_addr | d1_ram_wdata | d1_inst_rdata | d1_data_rdata, '0);
    step();
    resetn = 1'b1;
    @(negedge clk);
    chk("rmid_fresh_grant", {31'b0, d1_data_aok}, 32'd1);
    chk("rmid_no_dok", {30'b0, d1_inst_dok, d1_data_dok}, '0);
    step();
    drop_reqs();
    repeat (4) step();

    // RAM_LAT=3: data write arrives while a fetch is outstanding.
    do_reset();
    inst_req  = 1'b1;
    inst_addr = 32'hBFC00010;
    ram_rdata = 32'h3C1DBFC0;
    @(negedge clk);
    chk("dwf_inst_grant", {31'b0, d3_inst_aok}, 32'd1);
    step();
    inst_req   = 1'b0;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'd2;
    data_addr  = 32'h80007000;
    data_wdata = 32'h0BADCAFE;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("dwf_data_aok_T%0d", c), {31'b0, d3_data_aok}, '0);
      chk($sformatf("dwf_inst_dok_T%0d", c), {31'b0, d3_inst_dok}, {31'b0, (c == 3)});
      step();
    end
    @(negedge clk);
    chk("dwf_data_grant", {31'b0, d3_data_aok}, 32'd1);
    chk("dwf_data_wen", {28'b0, d3_ram_wen}, 32'hF);
    step();
    drop_reqs();
    step();
    step();
    @(negedge clk);
    chk("dwf_write_dok", {31'b0, d3_data_dok}, 32'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
